pot_scan_controller: RTL and testbench

Periodic sampling scheduler for the two paddle potentiometer PIO input ports of the Ping-Pong system. The two ports share one read-data return path. The block time-multiplexes that shared path by issuing one read per channel per sample period, then captures the 8-bit samples. It applies per-channel hysteresis and publishes stable paddle positions, with a valid strobe, to the game logic.

---
 rtl/pot_scan_controller_if.sv | 26 ++
 rtl/pot_scan_controller.sv | 136 +++++++++++++
 tb/tb_pot_scan_controller.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pot_scan_controller_if.sv
// Paddle potentiometer scan bus: shared PIO read path plus filtered position results.
// Latency: none (wires only); timing is owned by pot_scan_controller.
// Backpressure: none; the slave returns registered data one cycle after each read strobe.
interface pot_scan_if;
  logic        enable;
  logic [1:0]  pot_sel;
  logic        pot_read;
  logic [1:0]  pot_address;
  logic [31:0] pot_readdata;
  logic [7:0]  pos0;
  logic [7:0]  pos1;
  logic        pos_valid;
  logic        busy;

  // Controller side: drives the PIO selects/strobe and publishes positions.
  modport master (
    input  enable, pot_readdata,
    output pot_sel, pot_read, pot_address, pos0, pos1, pos_valid, busy
  );

  // PIO slaves and game logic side.
  modport slave (
    output enable, pot_readdata,
    input  pot_sel, pot_read, pot_address, pos0, pos1, pos_valid, busy
  );
endinterface

// File: rtl/pot_scan_controller.sv
// Periodic two-channel paddle pot scanner with per-channel hysteresis filtering.
// Latency: terminal count in cycle T -> REQ0 at T+1, new positions and pos_valid at T+6.
// Backpressure: none; fixed schedule, the timer keeps running during a scan.
module pot_scan_controller #(
  parameter int unsigned PERIOD = 50000,
  parameter int unsigned HYST   = 2
) (
  input  logic       clk,
  input  logic       reset,
  pot_scan_if.master bus
);

  if (PERIOD < 8 || PERIOD > 32'h00FF_FFFF) begin : g_bad_period
    $error("pot_scan_controller: PERIOD must be within 8..2^24-1");
  end
  if (HYST < 1 || HYST > 255) begin : g_bad_hyst
    $error("pot_scan_controller: HYST must be within 1..255");
  end

  localparam logic [23:0] TC_VAL  = 24'(PERIOD - 1);
  localparam logic [8:0]  HYST_TH = 9'(HYST);

  typedef enum logic [2:0] {IDLE, REQ0, CAP0, REQ1, CAP1, UPDATE} state_t;

  state_t      state;
  logic [23:0] timer;
  logic        term;
  logic        first;
  logic [7:0]  s0;
  logic [7:0]  s1;
  logic [7:0]  pos0_q;
  logic [7:0]  pos1_q;
  logic [1:0]  sel_q;
  logic        read_q;
  logic        valid_q;
  logic        busy_q;
  logic        unused_rd_hi;

  // Only the low byte of the slave word carries the sample.
  assign unused_rd_hi = ^bus.pot_readdata[31:8];

  assign term            = bus.enable && (timer == TC_VAL);
  assign bus.pot_address = 2'b00;
  assign bus.pot_sel     = sel_q;
  assign bus.pot_read    = read_q;
  assign bus.pos0        = pos0_q;
  assign bus.pos1        = pos1_q;
  assign bus.pos_valid   = valid_q;
  assign bus.busy        = busy_q;

  // Accept the new sample when loading unconditionally or when it moved by at
  // least HYST; the difference is taken in 9 bits so 0 vs 255 is 255, not 1.
  function automatic logic [7:0] filt(input logic [7:0] s, input logic [7:0] p,
                                      input logic load);
    logic signed [8:0] diff;
    logic [8:0]        mag;
    diff = $signed({1'b0, s}) - $signed({1'b0, p});
    mag  = diff[8] ? $unsigned(-diff) : $unsigned(diff);
    filt = (load || mag >= HYST_TH) ? s : p;
  endfunction

  // Free-running scan period timer; parked at 0 while disabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer <= '0;
    end else if (!bus.enable) begin
      timer <= '0;
    end else if (timer == TC_VAL) begin
      timer <= '0;
    end else begin
      timer <= timer + 24'd1;
    end
  end

  // Scan sequencer: outputs are registered on the transition into each state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      sel_q   <= 2'b00;
      read_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      pos0_q  <= '0;
      pos1_q  <= '0;
      s0      <= '0;
      s1      <= '0;
      first   <= 1'b1;
    end else begin
      valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (term) begin
            state  <= REQ0;
            sel_q  <= 2'b01;
            read_q <= 1'b1;
            busy_q <= 1'b1;
          end
        end
        REQ0: begin
          state  <= CAP0;
          read_q <= 1'b0;
        end
        CAP0: begin
          s0     <= bus.pot_readdata[7:0];
          state  <= REQ1;
          sel_q  <= 2'b10;
          read_q <= 1'b1;
        end
        REQ1: begin
          state  <= CAP1;
          read_q <= 1'b0;
        end
        CAP1: begin
          s1    <= bus.pot_readdata[7:0];
          state <= UPDATE;
          sel_q <= 2'b00;
        end
        UPDATE: begin
          pos0_q  <= filt(s0, pos0_q, first);
          pos1_q  <= filt(s1, pos1_q, first);
          first   <= 1'b0;
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state  <= IDLE;
          sel_q  <= 2'b00;
          read_q <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pot_scan_controller.sv
// Bench for pot_scan_controller: registered PIO slave model plus scan-level reference model.
// Latency checked: read strobes at T+1/T+3 after terminal count, positions at T+6.
// Backpressure: none; the slave answers every read strobe one cycle later.
module tb_pot_scan_controller;
  localparam int P = 8;
  localparam int H = 2;

  logic clk = 1'b0;
  logic reset;
  pot_scan_if bus ();

  pot_scan_controller #(.PERIOD(P), .HYST(H)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  // Reference model: period counter, position within a scan (-1 = idle,
  // 0..4 = cycles since the scan's first read), stored positions.
  int m_tmr, m_ph, m_first, m_pos0, m_pos1, m_valid, m_s0, m_s1;
  int ch0_val, ch1_val, pend;
  logic en_d, rst_d;
  int plan_q[$];
  bit saw_valid;
  int nvalid, nread;
  int c0 = -1, t_r0 = -1, t_r1 = -1, t_v = -1, t_r0b = -1;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    vectors++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    errors++;
    $display("FAIL %s: event not seen within bound (cycle %0d)", name, cyc);
  endtask

  function automatic int pick(input int cur);
    int v;
    if ($urandom_range(1) == 0) return int'($urandom_range(255));
    v = cur + int'($urandom_range(6)) - 3;
    if (v < 0) v = 0;
    if (v > 255) v = 255;
    return v;
  endfunction

  function automatic int next_val(input int cur);
    if (plan_q.size() > 0) return plan_q.pop_front();
    return pick(cur);
  endfunction

  function automatic int absdiff(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic model_reset();
    m_tmr = 0; m_ph = -1; m_first = 1; m_pos0 = 0; m_pos1 = 0;
    m_valid = 0; m_s0 = 0; m_s1 = 0;
  endtask

  task automatic model_step();
    int nph;
    if (rst_d) begin
      model_reset();
      return;
    end
    m_valid = (m_ph == 4);
    if (m_ph == 4) begin
      if (m_first != 0 || absdiff(m_s0, m_pos0) >= H) m_pos0 = m_s0;
      if (m_first != 0 || absdiff(m_s1, m_pos1) >= H) m_pos1 = m_s1;
      m_first = 0;
    end
    if (m_ph == 1) m_s0 = ch0_val;
    if (m_ph == 3) m_s1 = ch1_val;
    if (m_ph >= 0) nph = (m_ph == 4) ? -1 : m_ph + 1;
    else nph = (en_d && m_tmr == P - 1) ? 0 : -1;
    m_tmr = en_d ? ((m_tmr == P - 1) ? 0 : m_tmr + 1) : 0;
    m_ph = nph;
  endtask

  // One cycle: slave returns data after the edge, outputs compared at the falling edge.
  task automatic observe();
    logic [31:0] r;
    int v;
    int esel;
    @(posedge clk);
    #1;
    r = $urandom();
    v = (pend == 1) ? ch0_val : (pend == 2) ? ch1_val : int'($urandom_range(255));
    bus.pot_readdata = {r[31:8], v[7:0]};
    @(negedge clk);
    cyc++;
    esel = (m_ph == 0 || m_ph == 1) ? 1 : (m_ph == 2 || m_ph == 3) ? 2 : 0;
    chk("pot_sel", bus.pot_sel, esel);
    chk("pot_read", bus.pot_read, (m_ph == 0 || m_ph == 2) ? 1 : 0);
    chk("pot_address", bus.pot_address, 0);
    chk("busy", bus.busy, (m_ph >= 0) ? 1 : 0);
    chk("pos_valid", bus.pos_valid, m_valid);
    chk("pos0", bus.pos0, m_pos0);
    chk("pos1", bus.pos1, m_pos1);
    saw_valid = bus.pos_valid;
    if (bus.pos_valid) nvalid++;
    if (bus.pot_read) nread++;
    if (c0 >= 0) begin
      if (bus.pot_read && bus.pot_sel == 2'b01) begin
        if (t_r0 < 0) t_r0 = cyc - c0;
        else if (t_r0b < 0) t_r0b = cyc - c0;
      end
      if (bus.pot_read && bus.pot_sel == 2'b10 && t_r1 < 0) t_r1 = cyc - c0;
      if (bus.pos_valid && t_v < 0) t_v = cyc - c0;
    end
    pend = !bus.pot_read ? 0 : (bus.pot_sel == 2'b01) ? 1 : (bus.pot_sel == 2'b10) ? 2 : 0;
    if (m_ph == 0) ch0_val = next_val(m_pos0);
    if (m_ph == 2) ch1_val = next_val(m_pos1);
  endtask

  task automatic commit();
    reset = rst_d;
    bus.enable = en_d;
    model_step();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      observe();
      commit();
    end
  endtask

  task automatic wait_valid(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      observe();
      commit();
      ok = saw_valid;
    end
    if (!ok) timeout(name);
  endtask

  // Returns after observing (not committing) a cycle in model scan position p.
  task automatic wait_phase(input int p, input string name);
    for (int i = 0; i < 100; i++) begin
      observe();
      if (m_ph == p) return;
      commit();
    end
    timeout(name);
  endtask

  initial begin
    int rr, found;
    reset = 1'b1; rst_d = 1'b1; en_d = 1'b0;
    bus.enable = 1'b0; bus.pot_readdata = '0;
    pend = 0; ch0_val = 0; ch1_val = 0;
    model_reset();
    run(3);
    chk("reset_pos0", bus.pos0, 0);
    chk("reset_busy", bus.busy, 0);

    // Idle with enable low: nothing may be read.
    rst_d = 1'b0;
    nread = 0;
    run(100);
    chk("idle_reads", nread, 0);

    // Directed scans, then enable from "cycle 0".
    plan_q = '{8'h40, 8'hC8, 8'h41, 8'hC6, 8'hFF, 8'h80, 8'h00, 8'h81, 8'h01, 8'h82};
    observe();
    en_d = 1'b1;
    c0 = cyc;
    commit();
    wait_valid("scan1");
    chk("t_read_ch0", t_r0, 8);
    chk("t_read_ch1", t_r1, 10);
    chk("t_pos_valid", t_v, 13);
    chk("scan1_pos0", bus.pos0, 8'h40);
    chk("scan1_pos1", bus.pos1, 8'hC8);
    wait_valid("scan2");
    chk("t_next_read", t_r0b, 16);
    chk("scan2_pos0", bus.pos0, 8'h40);
    chk("scan2_pos1", bus.pos1, 8'hC6);
    wait_valid("scan3");
    chk("scan3_pos0", bus.pos0, 8'hFF);
    wait_valid("scan4");
    chk("scan4_pos0_nowrap", bus.pos0, 8'h00);
    wait_valid("scan5");
    chk("scan5_pos0_hold", bus.pos0, 8'h00);
    run(30 * P);

    // Drop enable during REQ1: scan completes, then silence.
    wait_phase(2, "reach_req1");
    en_d = 1'b0;
    commit();
    nvalid = 0;
    nread = 0;
    run(3 * P);
    chk("drop_valid_count", nvalid, 1);
    chk("drop_read_count", nread, 0);
    observe();
    en_d = 1'b1;
    rr = cyc;
    commit();
    found = -1;
    for (int i = 0; i < 30 && found < 0; i++) begin
      observe();
      if (bus.pot_read) found = cyc;
      commit();
    end
    if (found < 0) timeout("reenable_read");
    else chk("reenable_delay", found - rr, 8);

    // Reset during CAP0 with 0x77 pending.
    wait_valid("pre_reset_scan");
    plan_q.push_back(8'h77);
    plan_q.push_back(8'h55);
    wait_phase(1, "reach_cap0");
    rst_d = 1'b1;
    reset = 1'b1;
    #1;
    chk("rst_pos0", bus.pos0, 0);
    chk("rst_pos1", bus.pos1, 0);
    chk("rst_read", bus.pot_read, 0);
    chk("rst_sel", bus.pot_sel, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_valid", bus.pos_valid, 0);
    plan_q.delete();
    plan_q.push_back(8'h01);
    plan_q.push_back(8'h01);
    commit();
    observe();
    rst_d = 1'b0;
    commit();
    wait_valid("post_reset_scan");
    chk("post_reset_pos0", bus.pos0, 8'h01);
    chk("post_reset_pos1", bus.pos1, 8'h01);

    // Random traffic with occasional enable toggles and resets.
    for (int i = 0; i < 2500; i++) begin
      observe();
      if ($urandom_range(59) == 0) en_d = ~en_d;
      rst_d = ($urandom_range(399) == 0);
      commit();
    end
    rst_d = 1'b0;
    run(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
